// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
// Sequences a load / optional capture / unload test on an external scan chain.
//
// Ports:
//   CLK        - clock; all state updates on the rising edge
//   RN         - asynchronous active-low reset
//   START      - test request, sampled only while idle
//   CAPTURE_EN - latched at START; 1 inserts a capture cycle, 0 runs a flush test
//   ABORT      - synchronous abort of a running sequence
//   PAT_IN     - pattern to load; bit i targets chain stage i (latched at START)
//   SO         - scan output of the last chain stage
//   SE         - registered scan enable to every chain flop
//   SI         - registered scan input to chain stage 0
//   BUSY       - high in every state except idle
//   DONE       - one-cycle completion pulse
//   RESP_OUT   - unloaded response; bit i = value held by stage i before unload
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 6
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 START,
  input  logic                 CAPTURE_EN,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_UNLOAD  = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [CHAIN_LEN-1:0] pat_q,   pat_d;
  logic                 cap_q,   cap_d;
  logic                 se_q,    se_d;
  logic                 si_q,    si_d;
  logic [CHAIN_LEN-1:0] resp_q,  resp_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    cap_d   = cap_q;
    resp_d  = resp_q;

    case (state_q)
      S_IDLE: begin
        // ABORT outranks a simultaneous START
        if (START && !ABORT) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          pat_d   = PAT_IN;
          cap_d   = CAPTURE_EN;
        end
      end
      S_LOAD: begin
        if (ABORT) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = cap_q ? S_CAPTURE : S_UNLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        state_d = ABORT ? S_IDLE : S_UNLOAD;
        cnt_d   = '0;
      end
      S_UNLOAD: begin
        if (ABORT) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          // unload cycle k lands SO in bit CHAIN_LEN-1-k
          for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
            if (CNT_W'(CHAIN_LEN - 1 - i) == cnt_q) resp_d[i] = SO;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_FINISH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SE/SI are registered, so they are decoded from the upcoming state and
  // count: the value seen during load cycle k is PAT[CHAIN_LEN-1-k].
  always_comb begin
    se_d = (state_d == S_LOAD) || (state_d == S_UNLOAD);
    si_d = 1'b0;
    if (state_d == S_LOAD) begin
      for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
        if (CNT_W'(CHAIN_LEN - 1 - i) == cnt_d) si_d = pat_d[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      cap_q   <= 1'b0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      cap_q   <= cap_d;
      se_q    <= se_d;
      si_q    <= si_d;
      resp_q  <= resp_d;
    end
  end

  assign SE       = se_q;
  assign SI       = si_q;
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FINISH);
  assign RESP_OUT = resp_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with an 8-stage scan chain model.
module tb_scan_chain_ctrl;

  logic       CLK = 1'b0;
  logic       RN = 1'b0;
  logic       START = 1'b0;
  logic       CAPTURE_EN = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] PAT_IN = '0;
  logic       SO;
  logic       SE, SI, BUSY, DONE;
  logic [7:0] RESP_OUT;

  logic [7:0] chain_q = '0;
  logic [7:0] func_d  = 8'hF0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  scan_chain_ctrl #(.CHAIN_LEN(8), .CNT_W(6)) dut (
    .CLK        (CLK),
    .RN         (RN),
    .START      (START),
    .CAPTURE_EN (CAPTURE_EN),
    .ABORT      (ABORT),
    .PAT_IN     (PAT_IN),
    .SO         (SO),
    .SE         (SE),
    .SI         (SI),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .RESP_OUT   (RESP_OUT)
  );

  // scan chain: stage 0 fed by SI, stage 7 drives SO; functional D when SE=0
  always @(posedge CLK) begin
    if (SE) chain_q <= {chain_q[6:0], SI};
    else    chain_q <= func_d;
  end
  assign SO = chain_q[7];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // START on edge t, then log cycles t+1..t+30 (bit c of the vectors = cycle t+c)
  task automatic run(input logic [7:0] pat, input logic cap, input int abort_c,
                     input int restart_c, output logic [31:0] se_v,
                     output logic [31:0] si_v, output int done_cnt, output int done_c);
    se_v = '0; si_v = '0; done_cnt = 0; done_c = 0;
    PAT_IN = pat; CAPTURE_EN = cap; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    PAT_IN = ~pat;        // later changes must not disturb the sequence
    CAPTURE_EN = ~cap;
    for (int c = 1; c <= 30; c++) begin
      se_v[c] = SE;
      si_v[c] = SI;
      if (DONE) begin
        done_cnt++;
        if (done_c == 0) done_c = c;
      end
      ABORT = (c == abort_c);
      START = (c == restart_c);
      @(posedge CLK); #1;
    end
    ABORT = 1'b0;
    START = 1'b0;
  endtask

  logic [31:0] se_v, si_v;
  int          done_cnt, done_c;

  initial begin
    #12;
    check_eq("rst_se",   {31'd0, SE},   32'd0);
    check_eq("rst_si",   {31'd0, SI},   32'd0);
    check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
    check_eq("rst_done", {31'd0, DONE}, 32'd0);
    check_eq("rst_resp", {24'd0, RESP_OUT}, 32'd0);
    @(posedge CLK); #1;
    RN = 1'b1;
    @(posedge CLK); #1;

    // flush A5
    run(8'hA5, 1'b0, 0, 0, se_v, si_v, done_cnt, done_c);
    check_eq("flush_done_cyc", done_c, 17);
    check_eq("flush_done_cnt", done_cnt, 1);
    check_eq("flush_se",   se_v, 32'h0001_FFFE);
    check_eq("flush_si",   si_v & 32'h1FE, 32'h14A);
    check_eq("flush_resp", {24'd0, RESP_OUT}, 32'hA5);
    check_eq("flush_busy_end", {31'd0, BUSY}, 32'd0);

    // capture: D tied to F0, PAT_IN/CAPTURE_EN flipped after START
    run(8'h3C, 1'b1, 0, 0, se_v, si_v, done_cnt, done_c);
    check_eq("cap_done_cyc", done_c, 18);
    check_eq("cap_se",   se_v, 32'h0003_FDFE);
    check_eq("cap_si",   si_v & 32'h1FE, 32'h078);
    check_eq("cap_resp", {24'd0, RESP_OUT}, 32'hF0);

    // SI ordering with a single set MSB
    run(8'h80, 1'b0, 0, 0, se_v, si_v, done_cnt, done_c);
    check_eq("si80_si",   si_v, 32'h2);
    check_eq("si80_resp", {24'd0, RESP_OUT}, 32'h80);

    // abort in unload cycle 3 (cycle t+12): bits 7..5 already sampled from 5A
    run(8'h5A, 1'b0, 12, 0, se_v, si_v, done_cnt, done_c);
    check_eq("abort_done_cnt", done_cnt, 0);
    check_eq("abort_se",   se_v, 32'h0000_1FFE);
    check_eq("abort_busy", {31'd0, BUSY}, 32'd0);
    check_eq("abort_resp", {24'd0, RESP_OUT}, 32'h40);

    // ABORT and START together in idle
    ABORT = 1'b1; START = 1'b1; PAT_IN = 8'hFF;
    @(posedge CLK); #1;
    ABORT = 1'b0; START = 1'b0;
    check_eq("abort_start_busy", {31'd0, BUSY}, 32'd0);
    check_eq("abort_start_se",   {31'd0, SE},   32'd0);

    // repeated START while busy is ignored
    run(8'h96, 1'b0, 0, 5, se_v, si_v, done_cnt, done_c);
    check_eq("restart_done_cnt", done_cnt, 1);
    check_eq("restart_done_cyc", done_c, 17);
    check_eq("restart_resp", {24'd0, RESP_OUT}, 32'h96);

    // reset pulse mid-sequence at t+10
    PAT_IN = 8'h11; CAPTURE_EN = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge CLK); #1;
    end
    #2;
    RN = 1'b0;
    #1;
    check_eq("midrst_se",   {31'd0, SE},   32'd0);
    check_eq("midrst_si",   {31'd0, SI},   32'd0);
    check_eq("midrst_busy", {31'd0, BUSY}, 32'd0);
    check_eq("midrst_done", {31'd0, DONE}, 32'd0);
    check_eq("midrst_resp", {24'd0, RESP_OUT}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      if (DONE) done_cnt++;
    end
    check_eq("midrst_no_done", done_cnt, 0);
    RN = 1'b1;
    run(8'hC3, 1'b0, 0, 0, se_v, si_v, done_cnt, done_c);
    check_eq("postrst_done_cyc", done_c, 17);
    check_eq("postrst_resp", {24'd0, RESP_OUT}, 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8: number of scan flip-flops in the controlled chain, legal range 2..64.
REQ-002 SHALL have parameter CNT_W, default 6: width of the internal shift counter; must satisfy 2^CNT_W >= CHAIN_LEN.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port START  input  1  test request; sampled only in IDLE.
REQ-006 SHALL have port CAPTURE_EN  input  1  latched at START; 1 inserts capture cycle, 0 runs chain-integrity (flush) test.
REQ-007 SHALL have port ABORT  input  1  synchronous abort of a running sequence.
REQ-008 SHALL have port PAT_IN  input  CHAIN_LEN  pattern to load; bit i targets chain stage i; latched at START.
REQ-009 SHALL have port SO  input  1  scan output of chain (last stage, CHAIN_LEN-1).
REQ-010 SHALL have port SE  output  1  scan enable to every chain flop, registered.
REQ-011 SHALL have port SI  output  1  scan input to chain stage 0, registered.
REQ-012 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-013 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-014 SHALL have port RESP_OUT  output  CHAIN_LEN  unloaded response; bit i = value held by stage i before unload.

Function
REQ-015 SHALL implement states IDLE, LOAD, CAPTURE, UNLOAD, FINISH.
REQ-016 IDLE: SE=0, SI=0; START=1 at edge t latches PAT_IN and CAPTURE_EN, clears counter, enters LOAD.
REQ-017 LOAD: cycles t+1..t+CHAIN_LEN; SE=1; in load cycle k (k=0..CHAIN_LEN-1) SI=PAT[CHAIN_LEN-1-k] (MSB first).
REQ-018 After LOAD, latched CAPTURE_EN=1 SHALL enter CAPTURE; latched CAPTURE_EN=0 SHALL enter UNLOAD directly.
REQ-019 CAPTURE: exactly one cycle, SE=0, SI=0; chain captures functional D.
REQ-020 UNLOAD: CHAIN_LEN cycles; SE=1, SI=0; in unload cycle k SO SHALL be sampled at the closing edge into RESP_OUT[CHAIN_LEN-1-k].
REQ-021 FINISH: one cycle, SE=0, DONE=1, BUSY=1; then IDLE.
REQ-022 Latency START-edge to DONE-high: 2*CHAIN_LEN+2 cycles with capture, 2*CHAIN_LEN+1 without.
REQ-023 RESP_OUT SHALL update only during UNLOAD and hold its value in IDLE until the next UNLOAD begins.
REQ-024 Counter SHALL count 0..CHAIN_LEN-1 per shift phase and reset to 0 on every phase change; no wrap within a phase.
REQ-025 START while BUSY=1 SHALL be ignored (not queued).
REQ-026 ABORT=1 in LOAD, CAPTURE or UNLOAD SHALL enter IDLE at the next edge: SE=0, SI=0, no DONE, RESP_OUT unchanged from before abort except bits already sampled.
REQ-027 ABORT and START together in IDLE: ABORT has priority; START ignored.
REQ-028 ABORT in FINISH SHALL be ignored; DONE still pulses.
REQ-029 PAT_IN or CAPTURE_EN changes after START SHALL not affect the running sequence.

Reset
REQ-030 RN=0 SHALL asynchronously force state IDLE, counter 0, SE=0, SI=0, BUSY=0, DONE=0, RESP_OUT=0, latched pattern 0, latched CAPTURE_EN 0.
REQ-031 RN assertion mid-sequence SHALL abandon the sequence with no DONE; after RN rises, first START accepted on first rising edge with RN=1.

Verification
REQ-032 Flush: CHAIN_LEN=8, PAT_IN=8'hA5, CAPTURE_EN=0, SO driven by 8-stage chain model -> DONE at t+17, RESP_OUT=8'hA5, SE high for cycles t+1..t+16.
REQ-033 Capture: PAT_IN=8'h3C, CAPTURE_EN=1, chain D inputs tied to 8'hF0 -> SE low exactly at t+9, DONE at t+18, RESP_OUT=8'hF0.
REQ-034 SI order: PAT_IN=8'h80 -> SI=1 only in cycle t+1, 0 in t+2..t+8.
REQ-035 Abort: ABORT=1 during unload cycle 3 -> IDLE next edge, SE=0, DONE never pulses, BUSY=0.
REQ-036 Busy/reset: START repeated at t+5 ignored (DONE once); RN pulsed low at t+10 -> all outputs 0 immediately, new START then completes normally.
